// File: rtl/booth_digit_accum.sv
// Radix-4 Booth digit decoder/accumulator: one 3-bit window per transfer, 2N-bit signed product.
// Optional BOOTH_PP_TRACE_EN adds a registered per-digit weighted partial-product trace.
module booth_digit_accum #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   md,
   input  logic           dig_valid,
   input  logic [2:0]     dig,
   output logic           dig_ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] out
`ifdef BOOTH_PP_TRACE_EN
   ,
   output logic [2*N-1:0] pp_trace,
   output logic           pp_trace_valid
`endif
);

   localparam int D  = N / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   md_q, md_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] out_q, out_d;
   logic           done_q, done_d;

   logic           xfer;
   logic [N:0]     mag;
   logic           neg;
   logic [2*N-1:0] pp_sx;
   logic [2*N-1:0] pp_ext;
   logic [2*N-1:0] pp_w;

   assign busy      = (state_q == ACCUM);
   assign dig_ready = (state_q == ACCUM);
   assign xfer      = dig_valid & dig_ready;
   assign done      = done_q;
   assign out       = out_q;

   // Magnitude stays at N+1 bits; negation happens after widening so -2*(-2^(N-1)) is exact.
   always_comb begin
      mag = '0;
      neg = 1'b0;
      case (dig)
         3'b001, 3'b010: mag = {md_q[N-1], md_q};
         3'b011:         mag = {md_q, 1'b0};
         3'b100: begin
            mag = {md_q, 1'b0};
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            mag = {md_q[N-1], md_q};
            neg = 1'b1;
         end
         default: ;
      endcase
      pp_sx  = {{(N-1){mag[N]}}, mag};
      pp_ext = neg ? -pp_sx : pp_sx;
      pp_w   = pp_ext << {cnt_q, 1'b0};
   end

   // NOTE: every variable gets its hold/default value first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      md_d    = md_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               md_d    = md;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (xfer) begin
               acc_d = acc_q + pp_w;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(D - 1)) begin
                  out_d   = acc_q + pp_w;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         md_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         md_q    <= md_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

`ifdef BOOTH_PP_TRACE_EN
   logic [2*N-1:0] pp_trace_q;
   logic           pp_trace_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pp_trace_q       <= '0;
         pp_trace_valid_q <= 1'b0;
      end else begin
         pp_trace_valid_q <= xfer;
         if (xfer) pp_trace_q <= pp_w;
      end
   end

   assign pp_trace       = pp_trace_q;
   assign pp_trace_valid = pp_trace_valid_q;
`endif

endmodule

// File: tb/tb_booth_digit_accum.sv
// Directed scoreboard bench for booth_digit_accum: products checked against a plain signed multiply.
// Define BOOTH_PP_TRACE_EN for both files to also check the per-digit trace.
module tb_booth_digit_accum;

   localparam int N = 32;
   localparam int D = N / 2;

   logic           clk = 1'b0;
   logic           reset, start, dig_valid;
   logic [N-1:0]   md;
   logic [2:0]     dig;
   logic           dig_ready, busy, done;
   logic [2*N-1:0] out;
`ifdef BOOTH_PP_TRACE_EN
   logic [2*N-1:0] pp_trace;
   logic           pp_trace_valid;
   logic           trace_pend = 1'b0;
   logic [2*N-1:0] trace_exp;
   int             trace_pulses = 0;
`endif

   booth_digit_accum #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .md(md),
      .dig_valid(dig_valid), .dig(dig), .dig_ready(dig_ready),
      .busy(busy), .done(done), .out(out)
`ifdef BOOTH_PP_TRACE_EN
      , .pp_trace(pp_trace), .pp_trace_valid(pp_trace_valid)
`endif
   );

   always #5 clk = ~clk;

   int             errors = 0;
   int             checks = 0;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] last_out;
   logic [N-1:0]   cur_md;
   int             pos = -1000;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      logic signed [2*N-1:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   function automatic logic [2:0] win(input logic [N-1:0] mr, input int i);
      logic [N:0] e;
      e = {mr, 1'b0};
      return e[2*i +: 3];
   endfunction

   function automatic logic [2*N-1:0] pp_exp(input logic [N-1:0] m, input logic [2:0] w, input int i);
      logic signed [2*N-1:0] sm, v;
      sm = $signed(m);
      case (w)
         3'b001, 3'b010: v = sm;
         3'b011:         v = 2 * sm;
         3'b100:         v = -2 * sm;
         3'b101, 3'b110: v = -sm;
         default:        v = '0;
      endcase
      return v <<< (2 * i);
   endfunction

   // One cycle: land on the falling edge, sample, then release start.
   task automatic step();
      @(negedge clk);
      pos++;
      start = 1'b0;
      if (pos == 1) check("busy_after_start", busy, 1'b1);
`ifdef BOOTH_PP_TRACE_EN
      if (pp_trace_valid === 1'b1) trace_pulses++;
      if (trace_pend) begin
         check("trace_valid", pp_trace_valid, 1'b1);
         check("pp_trace", pp_trace, trace_exp);
      end else begin
         check("trace_idle", pp_trace_valid, 1'b0);
      end
      trace_pend = 1'b0;
`endif
   endtask

   task automatic send_start(input logic [N-1:0] a, input logic [N-1:0] b);
      start  = 1'b1;
      md     = a;
      cur_md = a;
      exp_q.push_back(model(a, b));
      pos = 0;
   endtask

   task automatic drive_digit(input logic [N-1:0] mr, input int i);
      dig_valid = 1'b1;
      dig       = win(mr, i);
`ifdef BOOTH_PP_TRACE_EN
      trace_pend = 1'b1;
      trace_exp  = pp_exp(cur_md, win(mr, i), i);
`endif
   endtask

   task automatic send_digits(input logic [N-1:0] mr, input int gap, input bit mid_start);
      for (int i = 0; i < D; i++) begin
         for (int g = 0; g < gap; g++) begin
            step();
            dig_valid = 1'b0;
            dig       = 3'($urandom);
         end
         step();
         drive_digit(mr, i);
         if (mid_start && i == D / 2) begin
            start = 1'b1;
            md    = ~md;
         end
      end
   endtask

   // Waits (bounded) for done, then pops the scoreboard and compares.
   task automatic finish_op(input string tag, input int exp_lat);
      int n;
      step();
      dig_valid = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      if (exp_lat > 0) check({tag, "_latency"}, pos, exp_lat);
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 1'b1, 1'b0);
         end else begin
            last_out = exp_q.pop_front();
            check({tag, "_out"}, out, last_out);
         end
      end
   endtask

   task automatic after_done(input string tag);
      step();
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_out_hold"}, out, last_out);
      check({tag, "_idle"}, {busy, dig_ready}, 2'b00);
   endtask

   task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input int gap, input int exp_lat);
      step();
      send_start(a, b);
      send_digits(b, gap, 1'b0);
      finish_op(tag, exp_lat);
      after_done(tag);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      reset = 1'b1; start = 1'b0; dig_valid = 1'b0; dig = '0; md = '0;
      repeat (2) step();
      check("reset_flags", {busy, dig_ready, done}, 3'b000);
      check("reset_out", out, '0);
      reset = 1'b0;

      // Digits offered in IDLE must be ignored.
      for (int k = 0; k < 3; k++) begin
         step();
         dig_valid = 1'b1;
         dig       = 3'b011;
      end
      step();
      dig_valid = 1'b0;
      check("idle_no_ready", {busy, dig_ready, done}, 3'b000);

`ifdef BOOTH_PP_TRACE_EN
      trace_pulses = 0;
`endif
      run("md3_mr5", 32'd3, 32'd5, 0, D + 1);
`ifdef BOOTH_PP_TRACE_EN
      check("trace_pulses", trace_pulses, D);
`endif
      run("neg7_x6_gap2", 32'hFFFF_FFF9, 32'd6, 2, D * 3 + 1);
      run("min_sq", 32'h8000_0000, 32'h8000_0000, 0, D + 1);
      run("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, D + 1);
      run("min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 1, D * 2 + 1);

      // Reset after five digits; same-cycle start and digit must lose to reset.
      step();
      send_start(32'h1234_5678, 32'h9ABC_DEF0);
      for (int i = 0; i < 5; i++) begin
         step();
         drive_digit(32'h9ABC_DEF0, i);
      end
      step();
      reset = 1'b1;
      start = 1'b1;
      drive_digit(32'h9ABC_DEF0, 5);
`ifdef BOOTH_PP_TRACE_EN
      trace_pend = 1'b0;
`endif
      step();
      check("rst_mid_flags", {busy, dig_ready, done}, 3'b000);
      check("rst_mid_out", out, '0);
      void'(exp_q.pop_back());
      reset = 1'b0;
      dig_valid = 1'b0;
      step();
      check("rst_mid_no_done", {busy, done}, 2'b00);
      run("fresh_after_rst", 32'h1234_5678, 32'h9ABC_DEF0, 0, D + 1);

      // Mid-operation start ignored; done-cycle start launches the next product.
      step();
      send_start(32'hDEAD_BEEF, 32'hB4E1_9C3A);
      send_digits(32'hB4E1_9C3A, 0, 1'b1);
      finish_op("mid_start", D + 1);
      send_start(32'h0000_7FFF, 32'hFFFF_FFFF);
      send_digits(32'hFFFF_FFFF, 0, 1'b0);
      finish_op("back_to_back", D + 1);
      after_done("back_to_back");

      for (int k = 0; k < 4; k++) begin
         ra = $urandom;
         rb = $urandom;
         run("random", ra, rb, k % 2, 0);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
